// File: rtl/calc_pkg.sv
// Shared constants for the four-function calculator core.
package calc_pkg;

    localparam logic [1:0] OP_MUL = 2'd0;
    localparam logic [1:0] OP_DIV = 2'd1;
    localparam logic [1:0] OP_SUB = 2'd2;
    localparam logic [1:0] OP_ADD = 2'd3;

    localparam int unsigned BCD_MAX = 9999;

endpackage

// File: rtl/btn_debouncer.sv
// Raw push-button to single-cycle press pulse: 2-flop sync, tick-sampled
// shift register, hysteretic level, rise detect.
module btn_debouncer #(
    parameter int unsigned DEB_SAMPLES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic i_tick,
    input  logic i_btn,
    output logic o_rise
);

    logic [1:0]             r_sync;
    logic [DEB_SAMPLES-1:0] r_shift;
    logic                   r_level;
    // Set once a debounced-low level is seen, so a button held through
    // reset cannot fire until it has been released and pressed again.
    logic                   r_armed;

    logic [DEB_SAMPLES-1:0] w_shift_next;
    logic                   w_all_ones;
    logic                   w_all_zeros;

    // Next shift-register content and its unanimity flags.
    always_comb begin
        w_shift_next = {r_shift[DEB_SAMPLES-2:0], r_sync[1]};
        w_all_ones   = &w_shift_next;
        w_all_zeros  = ~|w_shift_next;
    end

    // Synchronize, sample on tick, update level and emit the rise pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync  <= 2'b00;
            r_shift <= '0;
            r_level <= 1'b0;
            r_armed <= 1'b0;
            o_rise  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_btn};
            o_rise <= 1'b0;
            if (i_tick) begin
                r_shift <= w_shift_next;
                if (w_all_ones) begin
                    r_level <= 1'b1;
                    if (!r_level && r_armed) begin
                        o_rise <= 1'b1;
                    end
                end else if (w_all_zeros) begin
                    r_level <= 1'b0;
                    r_armed <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/calc_core.sv
// Calculator datapath/control: shared debounce tick, five debounced buttons,
// operand capture, registered ALU and saturating BCD conversion.
module calc_core
    import calc_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 100000,
    parameter int unsigned DEB_SAMPLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_add,
    input  logic        btn_sub,
    input  logic        btn_mul,
    input  logic        btn_div,
    input  logic        btn_clr,
    input  logic [15:0] sw,
    output logic [1:0]  opcode,
    output logic [15:0] result_bin,
    output logic [15:0] result_bcd,
    output logic        bcd_sat
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned N_BTN = 5;

    // Button index order: clr, add, sub, mul, div (descending priority).
    localparam int unsigned IDX_CLR = 4;
    localparam int unsigned IDX_ADD = 3;
    localparam int unsigned IDX_SUB = 2;
    localparam int unsigned IDX_MUL = 1;
    localparam int unsigned IDX_DIV = 0;

    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_a;
    logic [7:0]       r_b;

    logic             w_tick;
    logic [N_BTN-1:0] w_btn_raw;
    logic [N_BTN-1:0] w_rise;

    // Quotient is forced to zero on divide by zero.
    function automatic logic [15:0] alu(input logic [1:0] op,
                                        input logic [7:0] a,
                                        input logic [7:0] b);
        logic [15:0] r;
        case (op)
            OP_ADD:  r = 16'(a) + 16'(b);
            OP_SUB:  r = 16'(a) - 16'(b);
            OP_MUL:  r = 16'(a) * 16'(b);
            default: r = (b == 8'd0) ? 16'd0 : 16'(a / b);
        endcase
        return r;
    endfunction

    // Double-dabble; only called for values <= 9999 (fits 14 bits).
    function automatic logic [15:0] bin2bcd(input logic [13:0] v);
        logic [15:0] bcd;
        bcd = '0;
        for (int i = 13; i >= 0; i--) begin
            for (int d = 0; d < 4; d++) begin
                if (bcd[4*d +: 4] >= 4'd5) begin
                    bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
                end
            end
            bcd = {bcd[14:0], v[i]};
        end
        return bcd;
    endfunction

    assign w_tick    = (r_cnt == CNT_W'(TICK_DIV - 1));
    assign w_btn_raw = {btn_clr, btn_add, btn_sub, btn_mul, btn_div};

    // Shared debounce sample tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    for (genvar g = 0; g < N_BTN; g++) begin : g_deb
        btn_debouncer #(
            .DEB_SAMPLES(DEB_SAMPLES)
        ) u_deb (
            .clk    (clk),
            .reset  (reset),
            .i_tick (w_tick),
            .i_btn  (w_btn_raw[g]),
            .o_rise (w_rise[g])
        );
    end

    // Operand/opcode capture; highest-priority press wins.
    always_ff @(posedge clk) begin
        if (reset || w_rise[IDX_CLR]) begin
            r_a    <= 8'd0;
            r_b    <= 8'd0;
            opcode <= OP_MUL;
        end else if (w_rise[IDX_ADD]) begin
            r_a    <= sw[15:8];
            r_b    <= sw[7:0];
            opcode <= OP_ADD;
        end else if (w_rise[IDX_SUB]) begin
            r_a    <= sw[15:8];
            r_b    <= sw[7:0];
            opcode <= OP_SUB;
        end else if (w_rise[IDX_MUL]) begin
            r_a    <= sw[15:8];
            r_b    <= sw[7:0];
            opcode <= OP_MUL;
        end else if (w_rise[IDX_DIV]) begin
            r_a    <= sw[15:8];
            r_b    <= sw[7:0];
            opcode <= OP_DIV;
        end
    end

    // Registered ALU result.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_bin <= 16'd0;
        end else begin
            result_bin <= alu(opcode, r_a, r_b);
        end
    end

    // Registered BCD conversion, saturating above the 4-digit range.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_bcd <= 16'd0;
            bcd_sat    <= 1'b0;
        end else if (result_bin > 16'(BCD_MAX)) begin
            result_bcd <= 16'h9999;
            bcd_sat    <= 1'b1;
        end else begin
            result_bcd <= bin2bcd(result_bin[13:0]);
            bcd_sat    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_calc_core.sv
// Self-checking bench for calc_core with a fast debounce tick.
module tb_calc_core;

    localparam int TICK    = 4;
    localparam int HOLD    = 8 * TICK;
    localparam int SETTLE  = 8 * TICK;

    localparam logic [4:0] M_CLR = 5'b10000;
    localparam logic [4:0] M_ADD = 5'b01000;
    localparam logic [4:0] M_SUB = 5'b00100;
    localparam logic [4:0] M_MUL = 5'b00010;
    localparam logic [4:0] M_DIV = 5'b00001;

    localparam int C_MUL = 0;
    localparam int C_DIV = 1;
    localparam int C_SUB = 2;
    localparam int C_ADD = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        btn_add, btn_sub, btn_mul, btn_div, btn_clr;
    logic [15:0] sw;
    logic [1:0]  opcode;
    logic [15:0] result_bin;
    logic [15:0] result_bcd;
    logic        bcd_sat;

    int n_checks = 0;
    int n_fail   = 0;

    calc_core #(
        .TICK_DIV    (TICK),
        .DEB_SAMPLES (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_add    (btn_add),
        .btn_sub    (btn_sub),
        .btn_mul    (btn_mul),
        .btn_div    (btn_div),
        .btn_clr    (btn_clr),
        .sw         (sw),
        .opcode     (opcode),
        .result_bin (result_bin),
        .result_bcd (result_bcd),
        .bcd_sat    (bcd_sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_btns(input logic [4:0] m);
        {btn_clr, btn_add, btn_sub, btn_mul, btn_div} = m;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [4:0] m);
        set_btns(m);
        cycles(HOLD);
        set_btns(5'b0);
        cycles(SETTLE);
    endtask

    // Reference: arithmetic straight from the operation definitions.
    task automatic check_state(input string tag, input int op, input int a, input int b);
        int          r;
        logic [15:0] e_bcd;
        logic        e_sat;
        case (op)
            C_ADD:   r = a + b;
            C_SUB:   r = (a - b + 65536) % 65536;
            C_MUL:   r = a * b;
            default: r = (b == 0) ? 0 : a / b;
        endcase
        if (r > 9999) begin
            e_bcd = 16'h9999;
            e_sat = 1'b1;
        end else begin
            e_bcd = {4'(r / 1000), 4'((r / 100) % 10), 4'((r / 10) % 10), 4'(r % 10)};
            e_sat = 1'b0;
        end
        check({tag, ".opcode"}, 16'(opcode), 16'(op));
        check({tag, ".bin"}, result_bin, 16'(r));
        check({tag, ".bcd"}, result_bcd, e_bcd);
        check({tag, ".sat"}, 16'(bcd_sat), 16'(e_sat));
    endtask

    function automatic logic [4:0] op_mask(input int op);
        case (op)
            C_ADD:   return M_ADD;
            C_SUB:   return M_SUB;
            C_MUL:   return M_MUL;
            default: return M_DIV;
        endcase
    endfunction

    initial begin
        int op;
        logic [15:0] v;

        reset = 1'b1;
        set_btns(5'b0);
        sw = 16'h0000;
        cycles(5);
        check_state("reset", C_MUL, 0, 0);
        reset = 1'b0;
        cycles(SETTLE);

        // Directed operations.
        sw = 16'h0C05; press(M_ADD);
        check_state("add", C_ADD, 12, 5);
        check("add.bcd_exact", result_bcd, 16'h0017);
        sw = 16'h0305; press(M_SUB);
        check_state("sub_wrap", C_SUB, 3, 5);
        check("sub_wrap.bin_exact", result_bin, 16'hFFFE);
        sw = 16'hFFFF; press(M_MUL);
        check_state("mul_max", C_MUL, 255, 255);
        sw = 16'h6464; press(M_MUL);
        check_state("mul_10000", C_MUL, 100, 100);
        sw = 16'h6407; press(M_DIV);
        check_state("div", C_DIV, 100, 7);
        sw = 16'h6400; press(M_DIV);
        check_state("div0", C_DIV, 100, 0);

        // One-tick glitch must not register.
        sw = 16'h0C05; press(M_ADD);
        sw = 16'h2233;
        set_btns(M_SUB); cycles(TICK); set_btns(5'b0); cycles(SETTLE);
        check_state("bounce", C_ADD, 12, 5);

        // Simultaneous add and div: add wins.
        sw = 16'h1403; press(M_ADD | M_DIV);
        check_state("prio", C_ADD, 20, 3);

        // Long hold with switches changing afterwards: one capture only.
        sw = 16'h0A0B;
        set_btns(M_ADD);
        cycles(HOLD);
        sw = 16'h5566;
        cycles(20 * TICK);
        check_state("held", C_ADD, 10, 11);
        set_btns(5'b0);
        cycles(SETTLE);
        check_state("held_rel", C_ADD, 10, 11);

        // Randomized operations.
        for (int i = 0; i < 12; i++) begin
            op = int'($urandom_range(0, 3));
            v  = 16'($urandom);
            if (i == 3) v[7:0] = 8'd0;
            sw = v;
            press(op_mask(op));
            check_state($sformatf("rand%0d", i), op, int'(v[15:8]), int'(v[7:0]));
        end

        // Clear.
        press(M_CLR);
        check_state("clr", C_MUL, 0, 0);

        // Reset while a button is held: no event until released and repressed.
        sw = 16'h0C05;
        set_btns(M_ADD);
        cycles(HOLD);
        check_state("pre_rst", C_ADD, 12, 5);
        reset = 1'b1;
        cycles(3);
        reset = 1'b0;
        cycles(10 * TICK);
        check_state("rst_held", C_MUL, 0, 0);
        set_btns(5'b0);
        cycles(SETTLE);
        check_state("rst_rel", C_MUL, 0, 0);
        sw = 16'h0102; press(M_ADD);
        check_state("rst_repress", C_ADD, 1, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/calc_core.md
Name: calc_core

Overview:
- Datapath and control core of the 8-bit four-function calculator, one clock domain.
- Debounces five raw push-buttons (add, subtract, multiply, divide, clear).
- On an operation press, captures two 8-bit operands from the switches and computes the 16-bit result.
- Converts the result to four packed BCD digits for the 4-digit seven-segment driver that sits downstream.

Parameters:
- TICK_DIV, 100000: clk cycles per debounce sample tick (1 kHz at 100 MHz); benches use 4.
- DEB_SAMPLES, 3: consecutive equal samples required to change a debounced level; minimum 2.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- btn_add  in  1  raw add button, asynchronous, bouncy.
- btn_sub  in  1  raw subtract button, asynchronous, bouncy.
- btn_mul  in  1  raw multiply button, asynchronous, bouncy.
- btn_div  in  1  raw divide button, asynchronous, bouncy.
- btn_clr  in  1  raw clear button, asynchronous, bouncy.
- sw  in  16  operand switches: sw[15:8] = A, sw[7:0] = B, both unsigned.
- opcode  out  2  latched operation: 0 = MUL, 1 = DIV, 2 = SUB, 3 = ADD.
- result_bin  out  16  registered ALU result, drives the LEDs.
- result_bcd  out  16  packed BCD of result_bin, [15:12] = thousands.
- bcd_sat  out  1  high when result_bin > 9999.

Behaviour:
- Reset: tick counter, synchronizers, shift registers, debounced levels, operands, opcode, result_bin, result_bcd and bcd_sat all go to 0.
- Sample tick: a counter runs 0..TICK_DIV-1; the tick is a one-cycle pulse when the count equals TICK_DIV-1, then the counter wraps to 0.
- Synchronizer: each raw button passes through a 2-flop synchronizer.
- Debounce shift register: on each tick the synchronized value shifts into a DEB_SAMPLES-bit register.
  - All ones: debounced level goes to 1.
  - All zeros: debounced level goes to 0.
  - Otherwise: the level holds.
- Press event: a one-clk pulse on the rising edge of the debounced level. Holding a button produces no repeats. Releasing produces nothing.
- Event priority when several events occur in the same cycle: clr > add > sub > mul > div. Only the highest-priority event acts.
- clr event: operands A and B go to 0 and opcode goes to 0 (MUL), so result_bin becomes 0 one cycle later.
- Operation event: A <= sw[15:8], B <= sw[7:0], opcode <= code, all in the event cycle. Switches are ignored at all other times.
- ALU, registered every cycle from the operand registers and opcode:
  - ADD: zero-extended A + B, range 0..510.
  - SUB: (A - B) mod 2^16; B > A wraps, e.g. 3 - 5 = 0xFFFE.
  - MUL: A * B, full 16-bit product, no overflow possible.
  - DIV: integer quotient floor(A / B). If B = 0, result is 0x0000.
- BCD conversion, registered one cycle after result_bin:
  - result_bin <= 9999: exact 4-digit BCD, bcd_sat = 0.
  - result_bin > 9999: result_bcd = 0x9999, bcd_sat = 1.
  - Implemented as a combinational double-dabble or equivalent, then one register stage.
- Latency: event at cycle N → operands and opcode at N+1 → result_bin at N+2 → result_bcd and bcd_sat at N+3. Outputs hold until the next event.
- Reset asserted mid-press: all state clears. The button must be debounced low, then high again, to create a new event.
- Glitches shorter than DEB_SAMPLES ticks never change the debounced level.

Decomposition:
- Package calc_pkg:
  - opcode constants OP_MUL = 2'd0, OP_DIV = 2'd1, OP_SUB = 2'd2, OP_ADD = 2'd3.
  - BCD_MAX = 9999.
- One sub-module, btn_debouncer: synchronizer, shift register, level and rise pulse, with the sample tick as an input.
  - Instantiated five times.
  - One shared tick counter lives in calc_core.
- ALU and BCD conversion stay inline in calc_core as always blocks or functions.

Test Plan:
- Add: sw = 0x0C05, press btn_add (held ≥ 3 ticks) → opcode = 3, result_bin = 0x0011, result_bcd = 0x0017, bcd_sat = 0.
- Subtract with wrap: sw = 0x0305, press btn_sub → result_bin = 0xFFFE, result_bcd = 0x9999, bcd_sat = 1.
- Multiply: sw = 0xFFFF, press btn_mul → result_bin = 0xFE01 (65025), result_bcd = 0x9999.
- Multiply: sw = 0x6464 (100 × 100) → result_bin = 10000, bcd_sat = 1.
- Divide: sw = 0x6407, press btn_div → result_bin = 14, result_bcd = 0x0014.
- Divide by zero: sw = 0x6400 → result_bin = 0.
- Bounce rejection: btn_add toggled for 1 tick only → no event, outputs unchanged.
- Simultaneous btn_add and btn_div settling together → ADD is taken.
- Held button: btn_add held for 20 ticks while sw changes → exactly one capture.
- Clear and reset: btn_clr press after any result → result_bin = 0, result_bcd = 0x0000, opcode = 0.
- Reset during a held button → all outputs 0, and no event until the button is released and pressed again.
